// File: rtl/spi_apb_master_pkg.sv
// spi_apb_master_pkg: shared widths, FSM state and command/response types for the APB requester
package spi_apb_master_pkg;
  localparam int SPI_PADDR_WIDTH = 5;
  localparam int SPI_DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_e;
  typedef struct packed {
    logic write;
    logic [SPI_PADDR_WIDTH-1:0] addr;
    logic [SPI_DATA_WIDTH-1:0] wdata;
    logic [SPI_DATA_WIDTH/8-1:0] strb;
  } apb_cmd_t;
  typedef struct packed {
    logic [SPI_DATA_WIDTH-1:0] rdata;
    logic err;
  } apb_rsp_t;
endpackage

// File: rtl/spi_apb_master_if.sv
// spi_apb_master_if: command/response channels plus APB requester signals
interface spi_apb_master_if import spi_apb_master_pkg::*; #(
  parameter int ADDR_WIDTH = SPI_PADDR_WIDTH,
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
);
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_strb;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic psel, penable, pwrite, pready, pslverr;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata, prdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  modport master (
    input cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata, pstrb
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready, prdata, pready, pslverr,
    input cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/spi_apb_watchdog.sv
// spi_apb_watchdog: counts ACCESS cycles and flags the one that reaches TIMEOUT_CYCLES
module spi_apb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic clr,
  input  logic tick,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expired = tick && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (tick && !expired) cnt <= cnt + CW'(1);
endmodule

// File: rtl/spi_apb_master.sv
// spi_apb_master: one valid/ready command -> one APB transfer; ACCESS timeout abort under APB_MASTER_TIMEOUT_EN
module spi_apb_master import spi_apb_master_pkg::*; #(
  parameter int ADDR_WIDTH = SPI_PADDR_WIDTH,
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic pclk,
  input logic preset_n,
  spi_apb_master_if.master bus
);
  apb_mst_state_e state;
  logic timeout;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
`ifdef APB_MASTER_TIMEOUT_EN
  spi_apb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .pclk(pclk),
    .preset_n(preset_n),
    .clr(state == SETUP),
    .tick(state == ACCESS),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  assign bus.cmd_ready = state == IDLE;
  // pready is checked before timeout so a same-cycle pready completes normally
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      state <= IDLE;
      bus.psel <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite <= 1'b0;
      bus.paddr <= {ADDR_WIDTH{1'b0}};
      bus.pwdata <= {DATA_WIDTH{1'b0}};
      bus.pstrb <= {DATA_WIDTH/8{1'b0}};
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
      bus.rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          state <= SETUP;
          bus.psel <= 1'b1;
          bus.pwrite <= bus.cmd_write;
          bus.paddr <= bus.cmd_addr;
          bus.pwdata <= bus.cmd_wdata;
          bus.pstrb <= bus.cmd_strb;
        end
        SETUP: begin
          state <= ACCESS;
          bus.penable <= 1'b1;
        end
        ACCESS: if (bus.pready || timeout) begin
          state <= RESP;
          bus.psel <= 1'b0;
          bus.penable <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= (bus.pwrite || !bus.pready) ? {DATA_WIDTH{1'b0}} : bus.prdata;
          bus.rsp_err <= bus.pready ? bus.pslverr : 1'b1;
        end
        default: if (bus.rsp_ready) begin
          state <= IDLE;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
endmodule
